// File: rtl/bpqm_event_conditioner.sv
// Button front end for the bank queue manager: synchronise, debounce and edge-detect
// the arrival/service buttons, then gate them against a shadow occupancy count.
module bpqm_event_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DB_W            = 18,
    parameter int MAX_COUNT       = 7
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       arrive_btn,
    input  logic       serve_btn,
    output logic       countpb,
    output logic       upordown,
    output logic [2:0] occupancy,
    output logic       EF,
    output logic       FF,
    output logic       reject
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]      OCC_MAX = 3'(MAX_COUNT);

    // Bit 0 is the arrival button, bit 1 the service button.
    logic [1:0]      sync1_q, sync1_d;
    logic [1:0]      sync2_q, sync2_d;
    logic [1:0]      db_q, db_d;
    logic [1:0]      db_prev_q, db_prev_d;
    logic [1:0]      evt_q, evt_d;
    logic [DB_W-1:0] cnt_q [2];
    logic [DB_W-1:0] cnt_d [2];

    logic       pend_q, pend_d;
    logic       countpb_q, countpb_d;
    logic       upordown_q, upordown_d;
    logic [2:0] occ_q, occ_d;
    logic       ef_q, ef_d;
    logic       ff_q, ff_d;
    logic       reject_q, reject_d;

    logic do_arr;
    logic do_srv;

    always_comb begin
        sync1_d   = {serve_btn, arrive_btn};
        sync2_d   = sync1_q;
        db_d      = db_q;
        db_prev_d = db_q;
        evt_d     = db_q & ~db_prev_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // A pending service from a simultaneous press always wins its cycle; the arrival
    // of a simultaneous pair goes first so the service sees the updated occupancy.
    always_comb begin
        do_arr     = ~pend_q & evt_q[0];
        do_srv     = pend_q | (evt_q[1] & ~evt_q[0]);
        pend_d     = ~pend_q & evt_q[0] & evt_q[1];
        countpb_d  = 1'b0;
        reject_d   = 1'b0;
        upordown_d = upordown_q;
        occ_d      = occ_q;
        if (do_arr) begin
            if (occ_q < OCC_MAX) begin
                countpb_d  = 1'b1;
                upordown_d = 1'b1;
                occ_d      = occ_q + 3'd1;
            end else begin
                reject_d = 1'b1;
            end
        end else if (do_srv) begin
            if (occ_q != 3'd0) begin
                countpb_d  = 1'b1;
                upordown_d = 1'b0;
                occ_d      = occ_q - 3'd1;
            end else begin
                reject_d = 1'b1;
            end
        end
        ef_d = (occ_d == 3'd0);
        ff_d = (occ_d == OCC_MAX);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            db_prev_q  <= '0;
            evt_q      <= '0;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            pend_q     <= 1'b0;
            countpb_q  <= 1'b0;
            upordown_q <= 1'b1;
            occ_q      <= 3'd0;
            ef_q       <= 1'b1;
            ff_q       <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_q       <= db_d;
            db_prev_q  <= db_prev_d;
            evt_q      <= evt_d;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            pend_q     <= pend_d;
            countpb_q  <= countpb_d;
            upordown_q <= upordown_d;
            occ_q      <= occ_d;
            ef_q       <= ef_d;
            ff_q       <= ff_d;
            reject_q   <= reject_d;
        end
    end

    assign countpb   = countpb_q;
    assign upordown  = upordown_q;
    assign occupancy = occ_q;
    assign EF        = ef_q;
    assign FF        = ff_q;
    assign reject    = reject_q;

endmodule

// File: tb/tb_bpqm_event_conditioner.sv
// Directed bench for bpqm_event_conditioner with DEBOUNCE_CYCLES=4 (press-to-pulse = 8 edges).
module tb_bpqm_event_conditioner;

    logic       clk = 1'b0;
    logic       RST = 1'b0;
    logic       arrive_btn = 1'b0;
    logic       serve_btn = 1'b0;
    logic       countpb;
    logic       upordown;
    logic [2:0] occupancy;
    logic       EF;
    logic       FF;
    logic       reject;

    int n_assert = 0;
    int n_fail   = 0;
    int pb_cnt   = 0;
    int rej_cnt  = 0;
    logic last_up = 1'b1;

    bpqm_event_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .DB_W(18),
        .MAX_COUNT(7)
    ) dut (
        .clk(clk),
        .RST(RST),
        .arrive_btn(arrive_btn),
        .serve_btn(serve_btn),
        .countpb(countpb),
        .upordown(upordown),
        .occupancy(occupancy),
        .EF(EF),
        .FF(FF),
        .reject(reject)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles, tallying pulses and checking the per-cycle output invariants.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (countpb) begin
                pb_cnt++;
                last_up = upordown;
            end
            if (reject) rej_cnt++;
            check("ef_matches_occ", int'(EF), int'(occupancy == 3'd0));
            check("ff_matches_occ", int'(FF), int'(occupancy == 3'd7));
            check("no_pb_and_reject", int'(countpb & reject), 0);
        end
    endtask

    task automatic clear_tally();
        pb_cnt  = 0;
        rej_cnt = 0;
    endtask

    task automatic press(input logic arr, input logic srv);
        arrive_btn = arr;
        serve_btn  = srv;
        run_cycles(12);
        arrive_btn = 1'b0;
        serve_btn  = 1'b0;
        run_cycles(12);
    endtask

    initial begin
        logic [9:0] glitch;

        // Reset
        #2 RST = 1'b1;
        #1;
        check("rst_occ", int'(occupancy), 0);
        check("rst_ef", int'(EF), 1);
        check("rst_ff", int'(FF), 0);
        check("rst_countpb", int'(countpb), 0);
        check("rst_upordown", int'(upordown), 1);
        check("rst_reject", int'(reject), 0);
        tick();
        tick();
        RST = 1'b0;
        tick();

        // Clean arrival: pulse exactly 8 edges after the first high sample
        arrive_btn = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("clean_no_early_pb", int'(countpb), 0);
        end
        tick();
        check("clean_pb_edge8", int'(countpb), 1);
        check("clean_up", int'(upordown), 1);
        check("clean_occ", int'(occupancy), 1);
        check("clean_ef", int'(EF), 0);
        tick();
        check("clean_pb_one_cycle", int'(countpb), 0);
        clear_tally();
        run_cycles(11);
        arrive_btn = 1'b0;
        run_cycles(12);
        check("clean_no_more_pb", pb_cnt, 0);

        // Bouncy arrival: short glitches ignored, stable high counted once
        glitch = 10'b1101100101;
        clear_tally();
        for (int i = 0; i < 10; i++) begin
            arrive_btn = glitch[i];
            run_cycles(1);
        end
        check("bouncy_no_pb_in_glitch", pb_cnt, 0);
        press(1'b1, 1'b0);
        check("bouncy_one_pb", pb_cnt, 1);
        check("bouncy_occ", int'(occupancy), 2);

        // Drain to empty, then a service at empty is rejected
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        check("drain_occ", int'(occupancy), 0);
        clear_tally();
        press(1'b0, 1'b1);
        check("empty_srv_reject", rej_cnt, 1);
        check("empty_srv_no_pb", pb_cnt, 0);
        check("empty_srv_ef", int'(EF), 1);

        // Eight arrivals from empty
        for (int k = 1; k <= 7; k++) begin
            clear_tally();
            press(1'b1, 1'b0);
            check("fill_pb", pb_cnt, 1);
            check("fill_occ", int'(occupancy), k);
        end
        check("full_ff", int'(FF), 1);
        clear_tally();
        press(1'b1, 1'b0);
        check("full_arr_reject", rej_cnt, 1);
        check("full_arr_no_pb", pb_cnt, 0);
        check("full_arr_occ", int'(occupancy), 7);
        clear_tally();
        press(1'b0, 1'b1);
        check("full_srv_pb", pb_cnt, 1);
        check("full_srv_down", int'(last_up), 0);
        check("full_srv_occ", int'(occupancy), 6);
        check("full_srv_ff", int'(FF), 0);

        // Down to 3, then simultaneous presses
        for (int k = 0; k < 3; k++) press(1'b0, 1'b1);
        check("pre_sim_occ", int'(occupancy), 3);
        arrive_btn = 1'b1;
        serve_btn  = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        tick();
        check("sim_pb1", int'(countpb), 1);
        check("sim_up1", int'(upordown), 1);
        check("sim_occ1", int'(occupancy), 4);
        tick();
        check("sim_pb2", int'(countpb), 1);
        check("sim_up2", int'(upordown), 0);
        check("sim_occ2", int'(occupancy), 3);
        tick();
        check("sim_pb_end", int'(countpb), 0);
        arrive_btn = 1'b0;
        serve_btn  = 1'b0;
        run_cycles(12);

        // Simultaneous presses while full
        for (int k = 0; k < 4; k++) press(1'b1, 1'b0);
        check("pre_simfull_occ", int'(occupancy), 7);
        arrive_btn = 1'b1;
        serve_btn  = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        tick();
        check("simfull_reject", int'(reject), 1);
        check("simfull_no_pb", int'(countpb), 0);
        check("simfull_occ1", int'(occupancy), 7);
        tick();
        check("simfull_pb", int'(countpb), 1);
        check("simfull_down", int'(upordown), 0);
        check("simfull_occ2", int'(occupancy), 6);
        check("simfull_reject_clear", int'(reject), 0);
        arrive_btn = 1'b0;
        serve_btn  = 1'b0;
        run_cycles(12);

        // Reset one cycle after the arrival event is detected
        arrive_btn = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        RST = 1'b1;
        #1;
        check("midrst_countpb", int'(countpb), 0);
        check("midrst_occ", int'(occupancy), 0);
        check("midrst_ef", int'(EF), 1);
        check("midrst_ff", int'(FF), 0);
        check("midrst_up", int'(upordown), 1);
        tick();
        check("midrst_hold_pb", int'(countpb), 0);
        tick();
        RST = 1'b0;
        // Button still held across reset release: one event after the normal latency
        clear_tally();
        run_cycles(12);
        check("held_rst_pb", pb_cnt, 1);
        check("held_rst_occ", int'(occupancy), 1);
        arrive_btn = 1'b0;
        run_cycles(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bpqm_event_conditioner.md
Name: bpqm_event_conditioner

Overview:
- Upstream front end of the bank queue manager.
- Turns two raw, bouncy push buttons (customer arrival, teller served) into clean, single-cycle count pulses plus a direction level. These drive the queue manager's countpb and upordown inputs.
- Keeps a shadow occupancy (0..MAX_COUNT). It refuses increments when the queue is full and decrements when it is empty, so the downstream counter can never reach a forbidden state.
- Serialises simultaneous arrival/service events.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable clk cycles required before a button level is accepted (5 ms at 50 MHz); benches use 4.
- DB_W, 18, width of each debounce counter; must hold DEBOUNCE_CYCLES.
- MAX_COUNT, 7, full-queue occupancy.

Ports:
- clk  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- arrive_btn  in  1  raw arrival button, active-high, asynchronous to clk
- serve_btn  in  1  raw teller-served button, active-high, asynchronous to clk
- countpb  out  1  one-cycle count pulse to the queue manager
- upordown  out  1  1 = count up (arrival), 0 = count down (service); valid while countpb=1, held until the next accepted event
- occupancy  out  3  shadow customer count, 0..MAX_COUNT
- EF  out  1  occupancy == 0
- FF  out  1  occupancy == MAX_COUNT
- reject  out  1  one-cycle pulse when an event is dropped (arrival while full, or service while empty)

Behaviour:
- Reset (asynchronous, RST=1): countpb=0, upordown=1, occupancy=0, EF=1, FF=0, reject=0. Also cleared: synchronisers, debounce counters, debounced levels, and the pending-service flag. Reset mid-operation discards any pending event.
- Synchronisation: each button passes through a 2-flop synchroniser.
- Debounce, per button:
  - While the synchronised level equals the debounced level, the counter is 0.
  - While they differ, the counter increments every cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
  - Any mismatch gap shorter than DEBOUNCE_CYCLES cycles is ignored.
- Event: a rising edge of a debounced level (registered previous-value compare). Release edges generate nothing.
- Latency: a clean press produces countpb high exactly DEBOUNCE_CYCLES+4 rising edges after the first edge that samples the raw button high.
- Acceptance, evaluated in the event cycle; outputs are registered and appear on the next edge:
  - arrival and occupancy<MAX_COUNT: countpb=1, upordown=1, occupancy+1.
  - arrival and occupancy==MAX_COUNT: reject=1, no countpb, occupancy held.
  - service and occupancy>0: countpb=1, upordown=0, occupancy-1.
  - service and occupancy==0: reject=1, no countpb.
- Simultaneous arrival and service events in the same cycle:
  - The arrival is processed first and the service sets the pending flag.
  - The pending service is processed in the following cycle against the updated occupancy.
  - Result: countpb pulses on two consecutive cycles (up then down).
  - If full: the arrival is rejected (reject pulse), then the service is accepted.
- A pending service takes priority over a new event in its cycle. This cannot collide with a fresh edge because DEBOUNCE_CYCLES≥2.
- EF and FF are registered together with occupancy, so they always match it in the same cycle. occupancy never exceeds MAX_COUNT or goes below 0.
- countpb and reject are never high in the same cycle for the same event. Each pulse is exactly one cycle wide.
- A button held through reset release is debounced from a level of 0 and produces one event after the normal latency.

Test Plan:
- Setup: DEBOUNCE_CYCLES=4, RST pulse.
  - Required: occupancy=0, EF=1, FF=0, countpb=0, upordown=1.
- Clean arrival press held 20 cycles.
  - Required: countpb high for exactly 1 cycle, 8 edges after the first high sample; upordown=1; occupancy=1; EF=0.
- Bouncy arrival: 1-2-cycle high/low glitches for 10 cycles, then a stable high.
  - Required: exactly one countpb, no pulse during the glitches, occupancy +1.
- Eight arrivals from empty.
  - Required: occupancy 1..7; FF=1 after the 7th; the 8th gives a reject pulse, no countpb, occupancy stays 7. Then one service gives countpb with upordown=0, occupancy=6, FF=0.
- Service at occupancy=0.
  - Required: a reject pulse, no countpb, EF stays 1.
- Simultaneous presses at occupancy=3.
  - Required: countpb up pulse then down pulse on consecutive cycles; occupancy goes 4 then 3.
- Repeat simultaneous presses at occupancy=7.
  - Required: reject, then a down pulse; occupancy=6.
- Assert RST one cycle after an arrival event is detected.
  - Required: no countpb appears; all outputs return to reset values immediately.
